// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game match controller.
package game_pkg;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, GAP, DONE} state_e;

  localparam int unsigned SCORE_W = 13;
  localparam int unsigned TOTAL_W = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 13'd8191;

  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + {{(TOTAL_W + 1 - SCORE_W){1'b0}}, b};
    return s[TOTAL_W] ? '1 : s[TOTAL_W-1:0];
  endfunction

endpackage

// File: rtl/round_sequencer_tick_timer.sv
// Clear/enable cycle counter with a terminal-count compare against a runtime value.
module tick_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     count_q <= '0;
    else if (clr_i) count_q <= '0;
    else if (en_i)  count_q <= count_q + 1'b1;
  end

  assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/round_sequencer.sv
// Match-level controller: sequences NUM_ROUNDS rounds with timeout and inter-round gap.
// Optional DROP_WORST_EN: the final total excludes the worst charged round.
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned        NUM_ROUNDS    = 4,
  parameter int unsigned        TIMEOUT_TICKS = 50000000,
  parameter int unsigned        GAP_TICKS     = 10000000,
  parameter logic [SCORE_W-1:0] PENALTY       = SCORE_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_pulse,
  input  logic               abort_pulse,
  input  logic               round_valid,
  input  logic [SCORE_W-1:0] round_score,
  output logic               core_start,
  output logic               core_abort,
  output logic [2:0]         round_idx,
  output logic [TOTAL_W-1:0] total_score,
  output logic [SCORE_W-1:0] best_score,
  output logic               busy,
  output logic               match_done,
  output logic [6:0]         led_round
);

  localparam logic [31:0] WAIT_TC = 32'(TIMEOUT_TICKS - 1);
  localparam logic [31:0] GAP_TC  = 32'(GAP_TICKS - 1);

  state_e             state_q;
  logic               core_start_q, core_abort_q, busy_q, done_q;
  logic [2:0]         idx_q;
  logic [TOTAL_W-1:0] sum_q, sum_d;
  logic [SCORE_W-1:0] best_q, best_d, charge_score;
  logic [6:0]         led_q, led_d;
`ifdef DROP_WORST_EN
  logic [SCORE_W-1:0] worst_q, worst_d;
`endif

  logic        tmr_clr, tmr_en, tmr_tc, wait_end, gap_end, last_round;
  logic [31:0] tmr_tc_val;

  always_comb begin
    charge_score = round_valid ? round_score : PENALTY;
    sum_d        = sat_add(sum_q, charge_score);
    best_d       = (charge_score < best_q) ? charge_score : best_q;
    led_d        = led_q | (7'd1 << idx_q);
`ifdef DROP_WORST_EN
    worst_d      = (charge_score > worst_q) ? charge_score : worst_q;
`endif
    last_round   = (idx_q == 3'(NUM_ROUNDS - 1));
    wait_end     = (state_q == WAIT) && (round_valid || tmr_tc);
    gap_end      = (state_q == GAP) && tmr_tc;
    // Counter reads 0 in ARM and 1 in the first WAIT cycle, so timeout lands
    // TIMEOUT_TICKS cycles after core_start once the registered abort is counted.
    tmr_clr      = (state_q == IDLE) || (state_q == DONE) || wait_end || gap_end;
    tmr_en       = (state_q == ARM) || (state_q == WAIT) || (state_q == GAP);
    tmr_tc_val   = (state_q == GAP) ? GAP_TC : WAIT_TC;
  end

  tick_timer #(.W(32)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      core_start_q <= 1'b0;
      core_abort_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      idx_q        <= '0;
      sum_q        <= '0;
      best_q       <= SCORE_MAX;
      led_q        <= '0;
`ifdef DROP_WORST_EN
      worst_q      <= '0;
`endif
    end else begin
      core_start_q <= 1'b0;
      core_abort_q <= 1'b0;
      if ((state_q != IDLE) && abort_pulse) begin
        state_q      <= IDLE;
        core_abort_q <= 1'b1;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start_pulse) begin
              state_q      <= ARM;
              core_start_q <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              idx_q        <= '0;
              sum_q        <= '0;
              best_q       <= SCORE_MAX;
              led_q        <= '0;
`ifdef DROP_WORST_EN
              worst_q      <= '0;
`endif
            end
          end
          ARM: state_q <= WAIT;
          WAIT: begin
            if (wait_end) begin
              state_q      <= GAP;
              core_abort_q <= ~round_valid;
              sum_q        <= sum_d;
              best_q       <= best_d;
              led_q        <= led_d;
`ifdef DROP_WORST_EN
              worst_q      <= worst_d;
`endif
            end
          end
          GAP: begin
            if (gap_end) begin
              if (last_round) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`ifdef DROP_WORST_EN
                sum_q   <= sum_q - {{(TOTAL_W - SCORE_W){1'b0}}, worst_q};
`endif
              end else begin
                state_q      <= ARM;
                core_start_q <= 1'b1;
                idx_q        <= idx_q + 3'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign core_start  = core_start_q;
  assign core_abort  = core_abort_q;
  assign round_idx   = idx_q;
  assign total_score = sum_q;
  assign best_score  = best_q;
  assign busy        = busy_q;
  assign match_done  = done_q;
  assign led_round   = led_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer (short timeout/gap for simulation).
module tb_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start_pulse, abort_pulse, round_valid;
  logic [12:0] round_score;
  logic        core_start, core_abort, busy, match_done;
  logic [2:0]  round_idx;
  logic [15:0] total_score;
  logic [12:0] best_score;
  logic [6:0]  led_round;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, cs_cnt = 0, ca_cnt = 0;

  round_sequencer #(
    .NUM_ROUNDS   (4),
    .TIMEOUT_TICKS(100),
    .GAP_TICKS    (10),
    .PENALTY      (13'd8191)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_pulse(start_pulse),
    .abort_pulse(abort_pulse),
    .round_valid(round_valid),
    .round_score(round_score),
    .core_start (core_start),
    .core_abort (core_abort),
    .round_idx  (round_idx),
    .total_score(total_score),
    .best_score (best_score),
    .busy       (busy),
    .match_done (match_done),
    .led_round  (led_round)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (core_start) cs_cnt++;
    if (core_abort) ca_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    tick(1);
    start_pulse = 1'b0;
  endtask

  task automatic send_rv(input logic [12:0] s);
    round_valid = 1'b1;
    round_score = s;
    tick(1);
    round_valid = 1'b0;
  endtask

  task automatic wait_cs(input string tag, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!core_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(core_start), 32'd1);
    c = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!match_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(match_done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_total"}, 32'(total_score), 32'd0);
    check({tag, "_best"},  32'(best_score),  32'd8191);
    check({tag, "_led"},   32'(led_round),   32'd0);
    check({tag, "_idx"},   32'(round_idx),   32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_done"},  32'(match_done),  32'd0);
    check({tag, "_cs"},    32'(core_start),  32'd0);
    check({tag, "_ca"},    32'(core_abort),  32'd0);
  endtask

  int t1_sc  [4] = '{30, 60, 15, 90};
  int t1_tot [4] = '{30, 90, 105, 195};
  int t1_best[4] = '{30, 30, 15, 15};
  int t6_sc  [4] = '{10, 500, 20, 30};

  initial begin
    int c, a, c2, n;
    rst_n = 1'b0; start_pulse = 1'b0; abort_pulse = 1'b0;
    round_valid = 1'b0; round_score = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_reset_vals("rst");

    // 1: full match, all rounds scored
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    for (int r = 0; r < 4; r++) begin
      wait_cs("t1_cs_seen", c);
      check("t1_idx", 32'(round_idx), 32'(r));
      repeat (20) @(posedge clk);
      #1;
      send_rv(13'(t1_sc[r]));
      check("t1_run_total", 32'(total_score), 32'(t1_tot[r]));
      check("t1_run_best", 32'(best_score), 32'(t1_best[r]));
    end
    wait_done("t1_done_seen");
    tick(2);
    check("t1_total", 32'(total_score), 32'd195);
    check("t1_best", 32'(best_score), 32'd15);
    check("t1_led", 32'(led_round), 32'h0F);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_cs_count", 32'(cs_cnt), 32'd4);
    check("t1_ca_count", 32'(ca_cnt), 32'd0);

    // 2: timeout in round 0 of a fresh match started from DONE
    pulse_start();
    check("t2_clr_total", 32'(total_score), 32'd0);
    check("t2_clr_best", 32'(best_score), 32'd8191);
    check("t2_clr_led", 32'(led_round), 32'd0);
    check("t2_clr_done", 32'(match_done), 32'd0);
    wait_cs("t2_cs_seen", c);
    n = 0;
    @(negedge clk);
    while (!core_abort && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t2_abort_seen", 32'(core_abort), 32'd1);
    a = cyc;
    check("t2_abort_lat", 32'(a - c), 32'd100);
    check("t2_total", 32'(total_score), 32'd8191);
    check("t2_best", 32'(best_score), 32'd8191);
    check("t2_led", 32'(led_round), 32'h01);
    wait_cs("t2_cs2_seen", c2);
    check("t2_gap_lat", 32'(c2 - a), 32'd10);
    check("t2_idx", 32'(round_idx), 32'd1);

    // 3: round_valid exactly on the timeout cycle
    repeat (99) @(posedge clk);
    #1;
    send_rv(13'd5);
    tick(3);
    check("t3_no_abort", 32'(ca_cnt), 32'd1);
    check("t3_total", 32'(total_score), 32'd8196);
    check("t3_best", 32'(best_score), 32'd5);
    check("t3_led", 32'(led_round), 32'h03);

    // 4: abort and round_valid together
    wait_cs("t4_cs_seen", c);
    repeat (5) @(posedge clk);
    #1;
    abort_pulse = 1'b1; round_valid = 1'b1; round_score = 13'd7;
    tick(1);
    abort_pulse = 1'b0; round_valid = 1'b0;
    check("t4_core_abort", 32'(core_abort), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(match_done), 32'd0);
    check("t4_total", 32'(total_score), 32'd8196);
    check("t4_best", 32'(best_score), 32'd5);
    check("t4_led", 32'(led_round), 32'h03);
    n = cs_cnt;
    tick(30);
    check("t4_no_restart", 32'(cs_cnt), 32'(n));

    // 5: reset during GAP
    pulse_start();
    wait_cs("t5_cs_seen", c);
    repeat (3) @(posedge clk);
    #1;
    send_rv(13'd100);
    check("t5_pre_total", 32'(total_score), 32'd100);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check_reset_vals("t5");
    rst_n = 1'b1;
    n = cs_cnt;
    a = ca_cnt;
    tick(30);
    check("t5_no_cs", 32'(cs_cnt), 32'(n));
    check("t5_no_ca", 32'(ca_cnt), 32'(a));

    // 6: drop-worst scoring (or plain sum)
    pulse_start();
    for (int r = 0; r < 4; r++) begin
      wait_cs("t6_cs_seen", c);
      repeat (20) @(posedge clk);
      #1;
      send_rv(13'(t6_sc[r]));
    end
    wait_done("t6_done_seen");
    tick(1);
`ifdef DROP_WORST_EN
    check("t6_total", 32'(total_score), 32'd60);
`else
    check("t6_total", 32'(total_score), 32'd560);
`endif
    check("t6_best", 32'(best_score), 32'd10);
    check("t6_led", 32'(led_round), 32'h0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
